// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration controller: divider profile
// table (50 MHz reference) and controller state encoding.
package pll_cfg_pkg;

  localparam int NUM_PROFILE_ENTRIES = 3;
  localparam int MAX_OUT             = 7;

  typedef struct packed {
    logic [5:0]              idiv;
    logic [6:0]              mdiv;
    logic [MAX_OUT-1:0][6:0] odiv;
  } profile_t;

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_RUN,
    ST_GATE,
    ST_FAIL
  } state_t;

  function automatic profile_t mk_profile(input logic [5:0] i_idiv,
                                          input logic [6:0] i_mdiv,
                                          input logic [6:0] i_odiv0,
                                          input logic [6:0] i_odiv1);
    profile_t p;
    p         = '0;
    p.idiv    = i_idiv;
    p.mdiv    = i_mdiv;
    p.odiv[0] = i_odiv0;
    p.odiv[1] = i_odiv1;
    return p;
  endfunction

  // 0: VCO 1000 MHz -> 25/125 MHz; 1: VCO 1000 MHz -> 10/25 MHz; 2: VCO 1250 MHz -> 125/25 MHz
  localparam profile_t PROFILES [NUM_PROFILE_ENTRIES] = '{
    mk_profile(6'd1, 7'd20, 7'd40,  7'd8),
    mk_profile(6'd1, 7'd20, 7'd100, 7'd40),
    mk_profile(6'd2, 7'd50, 7'd10,  7'd50)
  };

  function automatic profile_t get_profile(input logic [7:0] idx);
    profile_t p;
    p = PROFILES[0];
    for (int k = 0; k < NUM_PROFILE_ENTRIES; k++) begin
      if (idx == 8'(k)) p = PROFILES[k];
    end
    return p;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the clkin domain.
module pll_lock_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Runtime PLL profile controller: gates outputs, reloads dividers, resets the
// PLL, waits for lock and settle, and recovers from lock loss with bounded retries.
module pll_reconfig_ctrl
  import pll_cfg_pkg::*;
#(
  parameter int NUM_OUT         = 2,
  parameter int NUM_PROFILES    = 3,
  parameter int DEFAULT_PROFILE = 0,
  parameter int RESET_CYCLES    = 16,
  parameter int LOCK_TIMEOUT    = 50000,
  parameter int SETTLE_CYCLES   = 256,
  parameter int GATE_CYCLES     = 4,
  parameter int MAX_RETRY       = 3,
  parameter int PW              = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
  input  logic                 clkin,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [PW-1:0]        req_profile,
  input  logic                 pll_lock,
  output logic                 pll_reset,
  output logic [5:0]           idiv,
  output logic [6:0]           mdiv,
  output logic [NUM_OUT*7-1:0] odiv,
  output logic [NUM_OUT-1:0]   clk_en,
  output logic                 ready,
  output logic [PW-1:0]        active_profile,
  output logic                 err,
  output logic [7:0]           relock_cnt
);

  localparam int CNT_MAX_A = (RESET_CYCLES > GATE_CYCLES) ? RESET_CYCLES : GATE_CYCLES;
  localparam int CNT_MAX_B = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int DW        = 6 + 7 + NUM_OUT * 7;

  localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] GATE_LAST    = CW'(GATE_CYCLES - 1);

  // Flatten a profile into {idiv, mdiv, odiv[NUM_OUT-1..0]} with channel 0 in the LSBs.
  function automatic logic [DW-1:0] prof_bits(input logic [7:0] idx);
    profile_t              p;
    logic [NUM_OUT*7-1:0]  o;
    p = get_profile(idx);
    o = '0;
    for (int c = 0; c < NUM_OUT; c++) o[c*7 +: 7] = p.odiv[c];
    return {p.idiv, p.mdiv, o};
  endfunction

  localparam logic [DW-1:0] DEF_BITS = prof_bits(8'(DEFAULT_PROFILE));

  state_t               r_state,     w_state_nxt;
  logic [CW-1:0]        r_cnt,       w_cnt_nxt;
  logic [RW-1:0]        r_retry,     w_retry_nxt;
  logic                 r_pll_reset, w_pll_reset_nxt;
  logic [NUM_OUT-1:0]   r_clk_en,    w_clk_en_nxt;
  logic                 r_ready,     w_ready_nxt;
  logic                 r_err,       w_err_nxt;
  logic [7:0]           r_relock,    w_relock_nxt;
  logic [PW-1:0]        r_active,    w_active_nxt;
  logic [PW-1:0]        r_pending,   w_pending_nxt;
  logic [DW-1:0]        r_div,       w_div_nxt;

  logic                 w_lock_s;
  logic                 w_req_ready;
  logic                 w_accept;
  logic                 w_in_range;
  logic [RW-1:0]        w_retry_inc;

  pll_lock_sync u_lock_sync (
    .i_clk   (clkin),
    .i_rst   (reset),
    .i_async (pll_lock),
    .o_sync  (w_lock_s)
  );

  assign w_req_ready = ((r_state == ST_RUN) && w_lock_s) || (r_state == ST_FAIL);
  assign w_accept    = req_valid && w_req_ready;
  assign w_in_range  = {1'b0, req_profile} < (PW+1)'(NUM_PROFILES);
  assign w_retry_inc = r_retry + 1'b1;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_retry_nxt     = r_retry;
    w_pll_reset_nxt = r_pll_reset;
    w_clk_en_nxt    = r_clk_en;
    w_ready_nxt     = r_ready;
    w_err_nxt       = r_err;
    w_relock_nxt    = r_relock;
    w_active_nxt    = r_active;
    w_pending_nxt   = r_pending;
    w_div_nxt       = r_div;

    case (r_state)
      ST_RESET_PLL: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == RESET_LAST) begin
          w_state_nxt     = ST_WAIT_LOCK;
          w_pll_reset_nxt = 1'b0;
          w_cnt_nxt       = '0;
        end
      end

      ST_WAIT_LOCK: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_lock_s) begin
          // the cycle that observed lock counts as the first settle cycle
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = CW'(1);
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_retry_nxt     = w_retry_inc;
          w_cnt_nxt       = '0;
          w_pll_reset_nxt = 1'b1;
          if (w_retry_inc < RW'(MAX_RETRY)) begin
            w_state_nxt = ST_RESET_PLL;
          end else begin
            w_state_nxt = ST_FAIL;
            w_err_nxt   = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (!w_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= SETTLE_LAST) begin
          w_state_nxt  = ST_RUN;
          w_clk_en_nxt = '1;
          w_ready_nxt  = 1'b1;
          w_retry_nxt  = '0;
          w_cnt_nxt    = '0;
        end
      end

      ST_RUN: begin
        if (!w_lock_s) begin
          w_relock_nxt    = (r_relock == 8'hFF) ? r_relock : r_relock + 8'd1;
          w_ready_nxt     = 1'b0;
          w_clk_en_nxt    = '0;
          w_retry_nxt     = '0;
          w_pll_reset_nxt = 1'b1;
          w_state_nxt     = ST_RESET_PLL;
          w_cnt_nxt       = '0;
        end else if (w_accept) begin
          if (w_in_range) begin
            w_pending_nxt = req_profile;
            w_err_nxt     = 1'b0;
            w_ready_nxt   = 1'b0;
            w_clk_en_nxt  = '0;
            w_state_nxt   = ST_GATE;
            w_cnt_nxt     = '0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      ST_GATE: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == GATE_LAST) begin
          w_div_nxt       = prof_bits(8'(r_pending));
          w_active_nxt    = r_pending;
          w_pll_reset_nxt = 1'b1;
          w_state_nxt     = ST_RESET_PLL;
          w_cnt_nxt       = '0;
        end
      end

      ST_FAIL: begin
        w_pll_reset_nxt = 1'b1;
        w_clk_en_nxt    = '0;
        w_ready_nxt     = 1'b0;
        if (w_accept) begin
          if (w_in_range) begin
            w_err_nxt     = 1'b0;
            w_retry_nxt   = '0;
            w_pending_nxt = req_profile;
            w_state_nxt   = ST_GATE;
            w_cnt_nxt     = '0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt     = ST_RESET_PLL;
        w_pll_reset_nxt = 1'b1;
        w_cnt_nxt       = '0;
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state     <= ST_RESET_PLL;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_pll_reset <= 1'b1;
      r_clk_en    <= '0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_relock    <= '0;
      r_active    <= PW'(DEFAULT_PROFILE);
      r_pending   <= PW'(DEFAULT_PROFILE);
      r_div       <= DEF_BITS;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      r_pll_reset <= w_pll_reset_nxt;
      r_clk_en    <= w_clk_en_nxt;
      r_ready     <= w_ready_nxt;
      r_err       <= w_err_nxt;
      r_relock    <= w_relock_nxt;
      r_active    <= w_active_nxt;
      r_pending   <= w_pending_nxt;
      r_div       <= w_div_nxt;
    end
  end

  assign req_ready      = w_req_ready;
  assign pll_reset      = r_pll_reset;
  assign {idiv, mdiv, odiv} = r_div;
  assign clk_en         = r_clk_en;
  assign ready          = r_ready;
  assign active_profile = r_active;
  assign err            = r_err;
  assign relock_cnt     = r_relock;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with a behavioural PLL lock model and a
// queue of expected profiles checked each time ready rises.
`timescale 1ns/1ps
module tb_pll_reconfig_ctrl;

  localparam int PW = 2;

  logic          clkin = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [PW-1:0] req_profile = '0;
  logic          pll_lock;
  logic          req_ready;
  logic          pll_reset;
  logic [5:0]    idiv;
  logic [6:0]    mdiv;
  logic [13:0]   odiv;
  logic [1:0]    clk_en;
  logic          ready;
  logic [PW-1:0] active_profile;
  logic          err;
  logic [7:0]    relock_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int sb_q[$];

  logic lock_en   = 1'b1;
  logic force_low = 1'b0;
  int   lock_dly  = 20;
  int   lcnt      = 0;

  pll_reconfig_ctrl #(
    .NUM_OUT(2), .NUM_PROFILES(3), .DEFAULT_PROFILE(0), .RESET_CYCLES(8),
    .LOCK_TIMEOUT(100), .SETTLE_CYCLES(16), .GATE_CYCLES(4), .MAX_RETRY(2)
  ) dut (
    .clkin(clkin), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_profile(req_profile), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .idiv(idiv), .mdiv(mdiv), .odiv(odiv), .clk_en(clk_en), .ready(ready),
    .active_profile(active_profile), .err(err), .relock_cnt(relock_cnt)
  );

  always #5 clkin = ~clkin;

  // PLL model: lock rises lock_dly cycles after pll_reset falls, drops while reset
  always @(posedge clkin) begin
    if (pll_reset) begin
      lcnt     <= 0;
      pll_lock <= 1'b0;
    end else begin
      lcnt     <= lcnt + 1;
      pll_lock <= lock_en && !force_low && (lcnt + 1 >= lock_dly);
    end
  end

  function automatic logic [26:0] exp_div(input int p);
    case (p)
      0:       return {6'd1, 7'd20, 7'd8,  7'd40};
      1:       return {6'd1, 7'd20, 7'd40, 7'd100};
      default: return {6'd2, 7'd50, 7'd50, 7'd10};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic wait_ready(input string tag, input int max_cyc, output int cyc);
    cyc = 0;
    while (ready !== 1'b1 && cyc < max_cyc) begin
      tick(1);
      cyc++;
    end
    check({tag, "_ready"}, ready, 1'b1);
  endtask

  task automatic sb_check(input string tag);
    int p;
    check({tag, "_sb_pending"}, sb_q.size() != 0, 1'b1);
    if (sb_q.size() != 0) begin
      p = sb_q.pop_front();
      check({tag, "_prof"}, active_profile, p);
      check({tag, "_div"}, {idiv, mdiv, odiv}, exp_div(p));
      check({tag, "_clk_en"}, clk_en, 2'b11);
    end
  endtask

  task automatic request(input int p);
    req_profile = p[PW-1:0];
    req_valid   = 1'b1;
    tick(1);
    req_valid   = 1'b0;
  endtask

  // Dividers may only move while the PLL is held in reset or all outputs are gated
  initial begin
    logic [26:0] prev;
    logic        have_prev;
    have_prev = 1'b0;
    prev      = '0;
    forever begin
      @(negedge clkin);
      if (reset === 1'b0 && have_prev && {idiv, mdiv, odiv} !== prev)
        check("div_guard", (pll_reset === 1'b1) || (clk_en === 2'b00), 1'b1);
      prev      = {idiv, mdiv, odiv};
      have_prev = (reset === 1'b0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int fall_at;
    int exp_rel;

    tick(3);
    check("rst_pll_reset", pll_reset, 1'b1);
    check("rst_clk_en", clk_en, 2'b00);
    check("rst_ready", ready, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_relock", relock_cnt, 8'd0);
    check("rst_prof", active_profile, 2'd0);
    check("rst_div", {idiv, mdiv, odiv}, exp_div(0));
    check("rst_req_ready", req_ready, 1'b0);

    sb_q.push_back(0);
    reset   = 1'b0;
    fall_at = -1;
    cyc     = 0;
    while (ready !== 1'b1 && cyc < 200) begin
      tick(1);
      cyc++;
      if (fall_at < 0 && pll_reset === 1'b0) fall_at = cyc;
    end
    check("boot_reset_len", fall_at, 8);
    check("boot_to_ready", cyc, 46);
    sb_check("boot");
    check("boot_req_ready", req_ready, 1'b1);

    // profile change 0 -> 1
    sb_q.push_back(1);
    request(1);
    check("gate_clk_en", clk_en, 2'b00);
    check("gate_ready", ready, 1'b0);
    check("gate_req_ready", req_ready, 1'b0);
    check("gate_pll_reset", pll_reset, 1'b0);
    tick(3);
    check("gate_hold_div", {idiv, mdiv, odiv}, exp_div(0));
    check("gate_hold_reset", pll_reset, 1'b0);
    tick(1);
    check("load_pll_reset", pll_reset, 1'b1);
    check("load_div", {idiv, mdiv, odiv}, exp_div(1));
    check("load_prof", active_profile, 2'd1);
    wait_ready("p1", 100, cyc);
    check("p1_latency", cyc, 46);
    sb_check("p1");

    // profile 2 with a 3-cycle lock glitch during SETTLE
    sb_q.push_back(2);
    request(2);
    tick(40);
    force_low = 1'b1;
    tick(3);
    force_low = 1'b0;
    wait_ready("glitch", 100, cyc);
    check("glitch_latency", cyc, 19);
    sb_check("glitch");

    // out-of-range request in RUN
    request(3);
    check("oor_err", err, 1'b1);
    check("oor_ready", ready, 1'b1);
    check("oor_prof", active_profile, 2'd2);
    check("oor_req_ready", req_ready, 1'b1);
    check("oor_div", {idiv, mdiv, odiv}, exp_div(2));

    // lock loss coinciding with a request: loss wins, no handshake
    force_low = 1'b1;
    tick(2);
    check("loss_ready_hold", ready, 1'b1);
    tick(1);
    req_profile = 2'd1;
    req_valid   = 1'b1;
    check("loss_req_ready", req_ready, 1'b0);
    check("loss_ready_late", ready, 1'b1);
    tick(1);
    req_valid = 1'b0;
    check("loss_ready_fall", ready, 1'b0);
    check("loss_pll_reset", pll_reset, 1'b1);
    check("loss_relock", relock_cnt, 8'd1);
    check("loss_err_kept", err, 1'b1);
    check("loss_clk_en", clk_en, 2'b00);
    force_low = 1'b0;
    sb_q.push_back(2);
    wait_ready("relock", 100, cyc);
    check("relock_latency", cyc, 46);
    sb_check("relock");

    // in-range request clears err
    sb_q.push_back(0);
    request(0);
    check("clr_err", err, 1'b0);
    wait_ready("p0", 100, cyc);
    sb_check("p0");

    // 300 lock losses: counter saturates, profile kept
    lock_dly = 1;
    exp_rel  = 1;
    for (int i = 0; i < 300; i++) begin
      force_low = 1'b1;
      cyc = 0;
      while (pll_reset !== 1'b1 && cyc < 10) begin
        tick(1);
        cyc++;
      end
      check("sat_loss", pll_reset, 1'b1);
      force_low = 1'b0;
      if (exp_rel < 255) exp_rel++;
      check("sat_cnt", relock_cnt, exp_rel);
      sb_q.push_back(0);
      wait_ready("sat", 100, cyc);
      sb_check("sat");
    end
    check("sat_final", relock_cnt, 8'd255);

    // lock never returns: two timeouts then FAIL
    lock_dly = 20;
    lock_en  = 1'b0;
    cyc = 0;
    while (pll_reset !== 1'b1 && cyc < 10) begin
      tick(1);
      cyc++;
    end
    check("to_loss", pll_reset, 1'b1);
    cyc = 0;
    while (err !== 1'b1 && cyc < 400) begin
      tick(1);
      cyc++;
    end
    check("to_fail_latency", cyc, 216);
    check("fail_err", err, 1'b1);
    check("fail_pll_reset", pll_reset, 1'b1);
    check("fail_req_ready", req_ready, 1'b1);
    check("fail_clk_en", clk_en, 2'b00);
    check("fail_ready", ready, 1'b0);
    check("fail_relock", relock_cnt, 8'd255);

    request(3);
    check("fail_oor_err", err, 1'b1);
    check("fail_oor_stay", req_ready, 1'b1);
    check("fail_oor_reset", pll_reset, 1'b1);

    lock_en = 1'b1;
    sb_q.push_back(1);
    request(1);
    check("recover_err", err, 1'b0);
    check("recover_req_ready", req_ready, 1'b0);
    check("recover_pll_reset", pll_reset, 1'b1);
    check("recover_clk_en", clk_en, 2'b00);
    tick(4);
    check("recover_div", {idiv, mdiv, odiv}, exp_div(1));
    check("recover_prof", active_profile, 2'd1);
    wait_ready("recover", 100, cyc);
    check("recover_latency", cyc, 46);
    sb_check("recover");

    // reset in the middle of a reconfiguration
    request(2);
    tick(6);
    check("mid_div_p2", {idiv, mdiv, odiv}, exp_div(2));
    reset = 1'b1;
    tick(1);
    check("mid_rst_div", {idiv, mdiv, odiv}, exp_div(0));
    check("mid_rst_prof", active_profile, 2'd0);
    check("mid_rst_pll_reset", pll_reset, 1'b1);
    check("mid_rst_ready", ready, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_relock", relock_cnt, 8'd0);
    check("mid_rst_clk_en", clk_en, 2'b00);
    reset = 1'b0;
    sb_q.push_back(0);
    wait_ready("post_rst", 100, cyc);
    check("post_rst_latency", cyc, 46);
    sb_check("post_rst");
    check("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
